// File: rtl/cache_pkg.sv
// Shared cache definitions: line-fetch command codes, line fetch FSM states
// and the access-controller status encodings.
package cache_pkg;

    localparam logic [1:0] FETCH_NONE    = 2'b00;
    localparam logic [1:0] FETCH_FILL    = 2'b01;
    localparam logic [1:0] FETCH_WB_FILL = 2'b10;

    typedef enum logic [2:0] {
        LFU_IDLE,
        LFU_WB_RD,
        LFU_WB_CAP,
        LFU_WB_WR,
        LFU_FILL_REQ,
        LFU_FILL_WAIT,
        LFU_FILL_WR,
        LFU_DONE
    } lfu_state_t;

    typedef enum logic [1:0] {
        PROC_IDLE = 2'b00,
        PROC_BUSY = 2'b01,
        PROC_HIT  = 2'b10,
        PROC_MISS = 2'b11
    } proc_status_t;

endpackage

// File: rtl/line_fetch_unit.sv
// Cache line fetch responder: optional victim writeback, then word-by-word refill.
// Defining LFU_PERF_CNT_EN adds saturating fill/writeback line counters.
module line_fetch_unit
    import cache_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32,
    localparam int TW = $clog2(list_depth),
    localparam int WW = $clog2(list_width)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    output logic                  fetch_gnt,
    input  logic [1:0]            fetch_cmd,
    input  logic [TW-1:0]         fetch_tag,
    input  logic [addr_width-1:0] fetch_addr,
    input  logic [addr_width-1:0] fetch_addr_pre,
    output logic                  fetch_done,
`ifdef LFU_PERF_CNT_EN
    output logic [15:0]           perf_fill_lines,
    output logic [15:0]           perf_wb_lines,
`endif
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [addr_width-1:0] bus_addr,
    output logic [data_width-1:0] bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [data_width-1:0] bus_rdata,
    output logic                  mem_ren,
    output logic [TW+WW-1:0]      mem_raddr,
    input  logic                  mem_rready,
    input  logic [data_width-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [TW+WW-1:0]      mem_waddr,
    output logic [data_width-1:0] mem_wdata,
    input  logic                  mem_wready
);

    localparam int BO = $clog2(data_width / 8);
    localparam int LO = WW + BO;
    localparam int LW = addr_width - LO;

    lfu_state_t            state_q, state_d;
    logic [TW-1:0]         tag_q, tag_d;
    logic [LW-1:0]         line_q, line_d;
    logic [LW-1:0]         line_pre_q, line_pre_d;
    logic [WW-1:0]         word_cnt_q, word_cnt_d;
    logic [data_width-1:0] wb_data_q, wb_data_d;
    logic [data_width-1:0] fill_data_q, fill_data_d;
    logic                  last_word;

    // Only the line number is kept; the request addresses are line aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[LO-1:0], fetch_addr_pre[LO-1:0]};

    assign last_word = (word_cnt_q == WW'(list_width - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LFU_IDLE;
            tag_q       <= '0;
            line_q      <= '0;
            line_pre_q  <= '0;
            word_cnt_q  <= '0;
            wb_data_q   <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            line_q      <= line_d;
            line_pre_q  <= line_pre_d;
            word_cnt_q  <= word_cnt_d;
            wb_data_q   <= wb_data_d;
            fill_data_q <= fill_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        line_d      = line_q;
        line_pre_d  = line_pre_q;
        word_cnt_d  = word_cnt_q;
        wb_data_d   = wb_data_q;
        fill_data_d = fill_data_q;
        fetch_gnt   = 1'b0;
        fetch_done  = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        mem_ren     = 1'b0;
        mem_raddr   = '0;
        mem_wen     = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        case (state_q)
            LFU_IDLE: begin
                fetch_gnt = 1'b1;
                if (fetch_req) begin
                    tag_d      = fetch_tag;
                    line_d     = fetch_addr[addr_width-1:LO];
                    line_pre_d = fetch_addr_pre[addr_width-1:LO];
                    word_cnt_d = '0;
                    case (fetch_cmd)
                        FETCH_FILL:    state_d = LFU_FILL_REQ;
                        FETCH_WB_FILL: state_d = LFU_WB_RD;
                        default:       state_d = LFU_DONE;
                    endcase
                end
            end
            LFU_WB_RD: begin
                mem_ren   = 1'b1;
                mem_raddr = {tag_q, word_cnt_q};
                if (mem_rready) state_d = LFU_WB_CAP;
            end
            LFU_WB_CAP: begin
                wb_data_d = mem_rdata;
                state_d   = LFU_WB_WR;
            end
            LFU_WB_WR: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = {line_pre_q, word_cnt_q, {BO{1'b0}}};
                bus_wdata = wb_data_q;
                if (bus_gnt) begin
                    // The counter wraps back to 0 after the last word, ready for the fill.
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = last_word ? LFU_FILL_REQ : LFU_WB_RD;
                end
            end
            LFU_FILL_REQ: begin
                bus_req  = 1'b1;
                bus_addr = {line_q, word_cnt_q, {BO{1'b0}}};
                if (bus_gnt) state_d = LFU_FILL_WAIT;
            end
            LFU_FILL_WAIT: begin
                if (bus_rvalid) begin
                    fill_data_d = bus_rdata;
                    state_d     = LFU_FILL_WR;
                end
            end
            LFU_FILL_WR: begin
                mem_wen   = 1'b1;
                mem_waddr = {tag_q, word_cnt_q};
                mem_wdata = fill_data_q;
                if (mem_wready) begin
                    if (last_word) begin
                        state_d = LFU_DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = LFU_FILL_REQ;
                    end
                end
            end
            LFU_DONE: begin
                fetch_done = 1'b1;
                state_d    = LFU_IDLE;
            end
            default: state_d = LFU_IDLE;
        endcase
    end

`ifdef LFU_PERF_CNT_EN
    logic        fill_op_q;
    logic [15:0] perf_fill_q;
    logic [15:0] perf_wb_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_op_q   <= 1'b0;
            perf_fill_q <= '0;
            perf_wb_q   <= '0;
        end else begin
            if (state_q == LFU_IDLE && fetch_req)
                fill_op_q <= (fetch_cmd == FETCH_FILL) || (fetch_cmd == FETCH_WB_FILL);
            if (state_q == LFU_DONE && fill_op_q && perf_fill_q != 16'hFFFF)
                perf_fill_q <= perf_fill_q + 16'd1;
            if (state_q == LFU_WB_WR && bus_gnt && last_word && perf_wb_q != 16'hFFFF)
                perf_wb_q <= perf_wb_q + 16'd1;
        end
    end

    assign perf_fill_lines = perf_fill_q;
    assign perf_wb_lines   = perf_wb_q;
`endif

endmodule
